music_sequencer: RTL

Playback controller for the song ROM (music_ROM, 8-bit address in, 8-bit note out, one-cycle registered read). It steps the ROM address from 0 up, holds each fetched note for a fixed beat length, and drives the held note to the downstream tone generator. It supports play, stop and pause, end-of-song detection and optional looping. The block sits between the user controls and the music_ROM/tone-generator pair.

---
 rtl/music_sequencer.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/music_sequencer.sv
// Song ROM playback controller: fetches notes from a one-cycle-latency ROM and holds each for a beat.
// Optional MUSIC_SEQ_NOTE_GAP_EN inserts a silent GAP state between notes.
module music_sequencer #(
    parameter int              ADDR_W      = 8,
    parameter int              NOTE_W      = 8,
    parameter int              SONG_LEN    = 200,
    parameter int              BEAT_CYCLES = 12500000,
    parameter logic [NOTE_W-1:0] END_CODE  = 8'hFF,
    parameter int              GAP_CYCLES  = 1250000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              play,
    input  logic              stop,
    input  logic              pause,
    input  logic              loop_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [NOTE_W-1:0] rom_note,
    output logic [NOTE_W-1:0] note,
    output logic              note_valid,
    output logic              playing,
    output logic              song_done
);

    localparam int BEAT_W = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEAT_CYCLES - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SONG_LEN - 1);

`ifdef MUSIC_SEQ_NOTE_GAP_EN
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HOLD, S_GAP} state_t;

    logic [GAP_W-1:0] gap_q, gap_d;
`else
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HOLD} state_t;
`endif

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [NOTE_W-1:0] note_q, note_d;
    logic              valid_q, valid_d;
    logic              playing_q, playing_d;
    logic              done_q, done_d;
    logic              fetch_q, fetch_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic              hold_done;
    logic              take_end;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        state_d   = state_q;
        addr_d    = addr_q;
        note_d    = note_q;
        valid_d   = valid_q;
        done_d    = 1'b0;
        fetch_d   = fetch_q;
        beat_d    = beat_q;
        hold_done = 1'b0;
        take_end  = 1'b0;
`ifdef MUSIC_SEQ_NOTE_GAP_EN
        gap_d     = gap_q;
`endif

        case (state_q)
            S_IDLE: begin
                addr_d = '0;
                if (play) begin
                    state_d = S_FETCH;
                    fetch_d = 1'b0;
                end
            end
            S_FETCH: begin
                if (!fetch_q) begin
                    fetch_d = 1'b1;
                end else begin
                    fetch_d = 1'b0;
                    if (rom_note == END_CODE) begin
                        take_end = 1'b1;
                    end else begin
                        note_d  = rom_note;
                        valid_d = 1'b1;
                        beat_d  = '0;
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (!pause) begin
                    if (beat_q == BEAT_LAST) begin
                        beat_d = '0;
`ifdef MUSIC_SEQ_NOTE_GAP_EN
                        state_d = S_GAP;
                        gap_d   = '0;
                        note_d  = '0;
                        valid_d = 1'b0;
`else
                        hold_done = 1'b1;
`endif
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
            end
`ifdef MUSIC_SEQ_NOTE_GAP_EN
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    gap_d     = '0;
                    hold_done = 1'b1;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

        // Beat (and gap) finished: step to the next address or finish the song.
        if (hold_done) begin
            if (addr_q == LAST_ADDR) begin
                take_end = 1'b1;
            end else begin
                addr_d  = addr_q + ADDR_W'(1);
                state_d = S_FETCH;
                fetch_d = 1'b0;
            end
        end

        if (take_end) begin
            addr_d = '0;
            if (loop_en) begin
                state_d = S_FETCH;
                fetch_d = 1'b0;
            end else begin
                state_d = S_IDLE;
                note_d  = '0;
                valid_d = 1'b0;
                done_d  = 1'b1;
            end
        end

        // stop overrides everything, including a simultaneous play in IDLE.
        if (stop) begin
            state_d = S_IDLE;
            addr_d  = '0;
            note_d  = '0;
            valid_d = 1'b0;
            done_d  = 1'b0;
            fetch_d = 1'b0;
            beat_d  = '0;
`ifdef MUSIC_SEQ_NOTE_GAP_EN
            gap_d   = '0;
`endif
        end

        playing_d = (state_d != S_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            note_q    <= '0;
            valid_q   <= 1'b0;
            playing_q <= 1'b0;
            done_q    <= 1'b0;
            fetch_q   <= 1'b0;
            beat_q    <= '0;
`ifdef MUSIC_SEQ_NOTE_GAP_EN
            gap_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            note_q    <= note_d;
            valid_q   <= valid_d;
            playing_q <= playing_d;
            done_q    <= done_d;
            fetch_q   <= fetch_d;
            beat_q    <= beat_d;
`ifdef MUSIC_SEQ_NOTE_GAP_EN
            gap_q     <= gap_d;
`endif
        end
    end

    assign rom_addr   = addr_q;
    assign note       = note_q;
    assign note_valid = valid_q;
    assign playing    = playing_q;
    assign song_done  = done_q;

endmodule
